// File: rtl/mm2_excp_commit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mm2_excp_commit_pkg
// Description : Shared definitions for the MM2 exception/ERTN commit path.
//               Holds exception codes, the exception-source bit order, the
//               FSM state encoding, the badv source selector and the decoded
//               op encodings that are shared with the rest of the pipeline.
// Config      : TLB_EXCP_EN - widens the exception vector from 6 to 12
//               sources (adds ADEM and the TLB-related exceptions).
// Revision    : 1.0 - initial release
// ============================================================================
package mm2_excp_commit_pkg;

`ifdef TLB_EXCP_EN
    localparam int NSRC = 12;
`else
    localparam int NSRC = 6;
`endif

    // Exception codes
    localparam logic [5:0] ECODE_INT  = 6'h00;
    localparam logic [5:0] ECODE_ADE  = 6'h08;   // ADEF (esub 0) and ADEM (esub 1)
    localparam logic [5:0] ECODE_INE  = 6'h0D;
    localparam logic [5:0] ECODE_SYS  = 6'h0B;
    localparam logic [5:0] ECODE_BRK  = 6'h0C;
    localparam logic [5:0] ECODE_ALE  = 6'h09;
    localparam logic [5:0] ECODE_TLBR = 6'h3F;
    localparam logic [5:0] ECODE_PIF  = 6'h03;
    localparam logic [5:0] ECODE_PIL  = 6'h01;
    localparam logic [5:0] ECODE_PIS  = 6'h02;
    localparam logic [5:0] ECODE_PME  = 6'h04;

    localparam logic [8:0] ESUBCODE_ADEM = 9'd1;

    // Exception vector bit positions; lower index = higher priority
    localparam logic [3:0] EXCP_IDX_INT  = 4'd0;
    localparam logic [3:0] EXCP_IDX_ADEF = 4'd1;
    localparam logic [3:0] EXCP_IDX_INE  = 4'd2;
    localparam logic [3:0] EXCP_IDX_SYS  = 4'd3;
    localparam logic [3:0] EXCP_IDX_BRK  = 4'd4;
    localparam logic [3:0] EXCP_IDX_ALE  = 4'd5;
    localparam logic [3:0] EXCP_IDX_ADEM = 4'd6;
    localparam logic [3:0] EXCP_IDX_TLBR = 4'd7;
    localparam logic [3:0] EXCP_IDX_PIF  = 4'd8;
    localparam logic [3:0] EXCP_IDX_PIL  = 4'd9;
    localparam logic [3:0] EXCP_IDX_PIS  = 4'd10;
    localparam logic [3:0] EXCP_IDX_PME  = 4'd11;

    // Commit FSM states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_FLUSH = 2'd2
    } state_e;

    // Where the bad virtual address comes from
    typedef enum logic [1:0] {
        BADV_NONE  = 2'd0,
        BADV_PC    = 2'd1,
        BADV_VADDR = 2'd2,
        BADV_TLBR  = 2'd3    // pc for fetch-class ops, vaddr otherwise
    } badv_sel_e;

    // Decoded op encodings shared with decode
    localparam logic [7:0] OP_NOP     = 8'h00;  // also marks a fetch-side fault
    localparam logic [7:0] OP_CSRWR   = 8'h20;
    localparam logic [7:0] OP_CSRXCHG = 8'h21;
    localparam logic [7:0] OP_ERTN    = 8'h30;

endpackage
`default_nettype wire

// File: rtl/mm2_excp_commit_excp_prio_enc.sv
`default_nettype none
// ============================================================================
// Module      : excp_prio_enc
// Description : Combinational fixed-priority encoder for the MM2 exception
//               vector. The lowest set bit wins and is mapped to its
//               ecode/esubcode and badv source.
// Ports       : i_vec      - exception flags (bit order = priority)
//               o_hit      - any flag set
//               o_ecode    - winning ecode
//               o_esubcode - winning esubcode (nonzero only for ADEM)
//               o_badv_sel - badv source for the winner
// Config      : TLB_EXCP_EN - decodes bits 6..11.
// Revision    : 1.0 - initial release
// ============================================================================
module excp_prio_enc
    import mm2_excp_commit_pkg::*;
#(
    parameter int N_SRC = NSRC
) (
    input  logic [N_SRC-1:0] i_vec,
    output logic             o_hit,
    output logic [5:0]       o_ecode,
    output logic [8:0]       o_esubcode,
    output badv_sel_e        o_badv_sel
);

    logic [3:0] w_idx;

    // Scan from the top down so the lowest set index is the last one written.
    always_comb begin
        o_hit = 1'b0;
        w_idx = 4'd0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (i_vec[i]) begin
                o_hit = 1'b1;
                w_idx = 4'(i);
            end
        end
    end

    always_comb begin
        o_ecode    = ECODE_INT;
        o_esubcode = 9'd0;
        o_badv_sel = BADV_NONE;
        if (o_hit) begin
            case (w_idx)
                EXCP_IDX_INT:  o_ecode = ECODE_INT;
                EXCP_IDX_ADEF: begin
                    o_ecode    = ECODE_ADE;
                    o_badv_sel = BADV_PC;
                end
                EXCP_IDX_INE:  o_ecode = ECODE_INE;
                EXCP_IDX_SYS:  o_ecode = ECODE_SYS;
                EXCP_IDX_BRK:  o_ecode = ECODE_BRK;
                EXCP_IDX_ALE:  begin
                    o_ecode    = ECODE_ALE;
                    o_badv_sel = BADV_VADDR;
                end
`ifdef TLB_EXCP_EN
                EXCP_IDX_ADEM: begin
                    o_ecode    = ECODE_ADE;
                    o_esubcode = ESUBCODE_ADEM;
                    o_badv_sel = BADV_VADDR;
                end
                EXCP_IDX_TLBR: begin
                    o_ecode    = ECODE_TLBR;
                    o_badv_sel = BADV_TLBR;
                end
                EXCP_IDX_PIF:  begin
                    o_ecode    = ECODE_PIF;
                    o_badv_sel = BADV_PC;
                end
                EXCP_IDX_PIL:  begin
                    o_ecode    = ECODE_PIL;
                    o_badv_sel = BADV_VADDR;
                end
                EXCP_IDX_PIS:  begin
                    o_ecode    = ECODE_PIS;
                    o_badv_sel = BADV_VADDR;
                end
                EXCP_IDX_PME:  begin
                    o_ecode    = ECODE_PME;
                    o_badv_sel = BADV_VADDR;
                end
`endif
                default: begin
                    o_ecode    = ECODE_INT;
                    o_esubcode = 9'd0;
                    o_badv_sel = BADV_NONE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/mm2_excp_commit.sv
`default_nettype none
// ============================================================================
// Module      : mm2_excp_commit
// Description : MM2-stage exception/ERTN commit controller. Accepts one
//               instruction in IDLE, latches its exception record, handshakes
//               with the CSR file (REQ) and then holds a pipeline flush for
//               FLUSH_CYC cycles (FLUSH). CSR writes are gated so that
//               excepting, ERTN or flushed instructions never write a CSR.
// Ports       : clk/reset (async, active high); mm2_* instruction inputs and
//               mm2_ready/mm2_csr_we; csr_* request/ack and latched exception
//               record; flush and one-cycle redirect_valid.
// Config      : TLB_EXCP_EN - 12-source exception vector (see package).
// Revision    : 1.0 - initial release
// ============================================================================
module mm2_excp_commit
    import mm2_excp_commit_pkg::*;
#(
    parameter int FLUSH_CYC = 2,
    parameter int PC_W      = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            mm2_valid,
    input  logic [7:0]      mm2_op,
    input  logic [PC_W-1:0] mm2_pc,
    input  logic [PC_W-1:0] mm2_vaddr,
    input  logic [NSRC-1:0] mm2_excp_vec,
    output logic            mm2_ready,
    output logic            mm2_csr_we,
    output logic            csr_excp_req,
    output logic            csr_ertn_req,
    input  logic            csr_ack,
    output logic [5:0]      csr_ecode,
    output logic [8:0]      csr_esubcode,
    output logic [PC_W-1:0] csr_era,
    output logic [PC_W-1:0] csr_badv,
    output logic            csr_badv_we,
    output logic            flush,
    output logic            redirect_valid
);

    localparam int               CNT_W      = $clog2(FLUSH_CYC + 1);
    localparam logic [CNT_W-1:0] c_cnt_load = CNT_W'(FLUSH_CYC - 1);
    localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);

    state_e            r_state;
    state_e            w_state_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_kind_excp;
    logic [5:0]        r_ecode;
    logic [8:0]        r_esub;
    logic [PC_W-1:0]   r_era;
    logic [PC_W-1:0]   r_badv;
    logic              r_badv_we;

    logic              w_hit;
    logic [5:0]        w_ecode;
    logic [8:0]        w_esub;
    badv_sel_e         w_badv_sel;
    logic [PC_W-1:0]   w_badv;
    logic              w_badv_we;
    logic              w_accept;
    logic              w_start_excp;
    logic              w_start_ertn;
    logic              w_is_csr_wr;

    excp_prio_enc #(
        .N_SRC (NSRC)
    ) u_prio_enc (
        .i_vec      (mm2_excp_vec),
        .o_hit      (w_hit),
        .o_ecode    (w_ecode),
        .o_esubcode (w_esub),
        .o_badv_sel (w_badv_sel)
    );

    // Acceptance depends only on the state register so the FSM's comb block
    // does not consume its own output.
    assign w_accept     = mm2_valid & (r_state == ST_IDLE);
    assign w_start_excp = w_accept & w_hit;
    // An exception always wins over ERTN in the same instruction.
    assign w_start_ertn = w_accept & ~w_hit & (mm2_op == OP_ERTN);
    assign w_is_csr_wr  = (mm2_op == OP_CSRWR) | (mm2_op == OP_CSRXCHG);

    always_comb begin
        w_badv    = '0;
        w_badv_we = 1'b0;
        case (w_badv_sel)
            BADV_PC: begin
                w_badv    = mm2_pc;
                w_badv_we = 1'b1;
            end
            BADV_VADDR: begin
                w_badv    = mm2_vaddr;
                w_badv_we = 1'b1;
            end
            BADV_TLBR: begin
                // Decode tags fetch-side TLB faults with an OP_NOP op.
                w_badv    = (mm2_op == OP_NOP) ? mm2_pc : mm2_vaddr;
                w_badv_we = 1'b1;
            end
            default: begin
                w_badv    = '0;
                w_badv_we = 1'b0;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and state-decoded outputs
    always_comb begin
        w_state_nxt    = r_state;
        mm2_ready      = 1'b0;
        mm2_csr_we     = 1'b0;
        csr_excp_req   = 1'b0;
        csr_ertn_req   = 1'b0;
        flush          = 1'b0;
        redirect_valid = 1'b0;
        case (r_state)
            ST_IDLE: begin
                mm2_ready  = 1'b1;
                mm2_csr_we = mm2_valid & ~w_hit & w_is_csr_wr;
                if (w_start_excp || w_start_ertn) begin
                    w_state_nxt = ST_REQ;
                end
            end
            ST_REQ: begin
                csr_excp_req = r_kind_excp;
                csr_ertn_req = ~r_kind_excp;
                if (csr_ack) begin
                    w_state_nxt = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                flush = 1'b1;
                // The counter still holds its load value only in the first
                // flush cycle.
                redirect_valid = (r_cnt == c_cnt_load);
                if (r_cnt == '0) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Exception record and flush counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt       <= '0;
            r_kind_excp <= 1'b0;
            r_ecode     <= '0;
            r_esub      <= '0;
            r_era       <= '0;
            r_badv      <= '0;
            r_badv_we   <= 1'b0;
        end else begin
            if (w_start_excp) begin
                r_kind_excp <= 1'b1;
                r_ecode     <= w_ecode;
                r_esub      <= w_esub;
                r_era       <= mm2_pc;
                r_badv      <= w_badv;
                r_badv_we   <= w_badv_we;
            end else if (w_start_ertn) begin
                r_kind_excp <= 1'b0;
                r_badv_we   <= 1'b0;
            end

            if ((r_state == ST_REQ) && csr_ack) begin
                r_cnt <= c_cnt_load;
            end else if ((r_state == ST_FLUSH) && (r_cnt != '0)) begin
                r_cnt <= r_cnt - c_cnt_one;
            end
        end
    end

    assign csr_ecode    = r_ecode;
    assign csr_esubcode = r_esub;
    assign csr_era      = r_era;
    assign csr_badv     = r_badv;
    assign csr_badv_we  = r_badv_we;

endmodule
`default_nettype wire

// File: tb/tb_mm2_excp_commit.sv
`default_nettype none
// ============================================================================
// Module      : tb_mm2_excp_commit
// Description : Directed self-checking bench for mm2_excp_commit with
//               FLUSH_CYC=2, PC_W=32. The ADEM/TLBR cases are compiled only
//               when TLB_EXCP_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mm2_excp_commit;
    import mm2_excp_commit_pkg::*;

    localparam int FC = 2;
    localparam int PW = 32;

    logic            clk;
    logic            reset;
    logic            mm2_valid;
    logic [7:0]      mm2_op;
    logic [PW-1:0]   mm2_pc;
    logic [PW-1:0]   mm2_vaddr;
    logic [NSRC-1:0] mm2_excp_vec;
    logic            mm2_ready;
    logic            mm2_csr_we;
    logic            csr_excp_req;
    logic            csr_ertn_req;
    logic            csr_ack;
    logic [5:0]      csr_ecode;
    logic [8:0]      csr_esubcode;
    logic [PW-1:0]   csr_era;
    logic [PW-1:0]   csr_badv;
    logic            csr_badv_we;
    logic            flush;
    logic            redirect_valid;

    int r_checks = 0;
    int r_errors = 0;

    mm2_excp_commit #(
        .FLUSH_CYC (FC),
        .PC_W      (PW)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .mm2_valid      (mm2_valid),
        .mm2_op         (mm2_op),
        .mm2_pc         (mm2_pc),
        .mm2_vaddr      (mm2_vaddr),
        .mm2_excp_vec   (mm2_excp_vec),
        .mm2_ready      (mm2_ready),
        .mm2_csr_we     (mm2_csr_we),
        .csr_excp_req   (csr_excp_req),
        .csr_ertn_req   (csr_ertn_req),
        .csr_ack        (csr_ack),
        .csr_ecode      (csr_ecode),
        .csr_esubcode   (csr_esubcode),
        .csr_era        (csr_era),
        .csr_badv       (csr_badv),
        .csr_badv_we    (csr_badv_we),
        .flush          (flush),
        .redirect_valid (redirect_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        r_checks++;
        if (obs !== exp) begin
            r_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called in the first REQ cycle: ack there, then run out the flush.
    task automatic finish_req(input string tag);
        csr_ack = 1'b1;
        tick();
        csr_ack = 1'b0;
        repeat (FC) tick();
        check({tag, "_back_idle"}, 64'(mm2_ready), 64'd1);
    endtask

    initial begin
        reset        = 1'b1;
        mm2_valid    = 1'b0;
        mm2_op       = OP_NOP;
        mm2_pc       = '0;
        mm2_vaddr    = '0;
        mm2_excp_vec = '0;
        csr_ack      = 1'b0;
        repeat (2) tick();

        // ---------------- reset values ----------------
        check("rst_ready", 64'(mm2_ready),      64'd1);
        check("rst_req",   64'(csr_excp_req),   64'd0);
        check("rst_ertn",  64'(csr_ertn_req),   64'd0);
        check("rst_flush", 64'(flush),          64'd0);
        check("rst_redir", 64'(redirect_valid), 64'd0);
        check("rst_ecode", 64'(csr_ecode),      64'd0);
        check("rst_era",   64'(csr_era),        64'd0);
        reset = 1'b0;
        tick();

        // ---------------- baseline SYS, ack after 3 cycles ----------------
        mm2_valid    = 1'b1;
        mm2_op       = OP_NOP;
        mm2_excp_vec = NSRC'(6'b001000);
        mm2_pc       = 32'h1c00_0100;
        mm2_vaddr    = 32'h0000_0040;
        #1;
        check("sys_T_ready", 64'(mm2_ready), 64'd1);
        tick();                                   // T+1
        mm2_valid    = 1'b0;
        mm2_excp_vec = '0;
        check("sys_T1_req",   64'(csr_excp_req), 64'd1);
        check("sys_T1_ertn",  64'(csr_ertn_req), 64'd0);
        check("sys_T1_ready", 64'(mm2_ready),    64'd0);
        check("sys_ecode",    64'(csr_ecode),    64'h0B);
        check("sys_esub",     64'(csr_esubcode), 64'd0);
        check("sys_badv_we",  64'(csr_badv_we),  64'd0);
        check("sys_era",      64'(csr_era),      64'h1c00_0100);
        tick();                                   // T+2
        check("sys_T2_req", 64'(csr_excp_req), 64'd1);
        // A CSR write arriving while busy must neither write nor be taken.
        mm2_valid    = 1'b1;
        mm2_op       = OP_CSRWR;
        mm2_excp_vec = NSRC'(6'b000100);
        mm2_pc       = 32'h1c00_0200;
        #1;
        check("busy_csr_we", 64'(mm2_csr_we), 64'd0);
        tick();                                   // T+3
        mm2_valid    = 1'b0;
        mm2_excp_vec = '0;
        check("sys_T3_req",   64'(csr_excp_req), 64'd1);
        check("sys_T3_ecode", 64'(csr_ecode),    64'h0B);
        check("sys_T3_era",   64'(csr_era),      64'h1c00_0100);
        csr_ack = 1'b1;
        tick();                                   // T+4
        csr_ack = 1'b0;
        check("sys_T4_flush", 64'(flush),          64'd1);
        check("sys_T4_redir", 64'(redirect_valid), 64'd1);
        check("sys_T4_req",   64'(csr_excp_req),   64'd0);
        check("sys_T4_ready", 64'(mm2_ready),      64'd0);
        tick();                                   // T+5
        check("sys_T5_flush", 64'(flush),          64'd1);
        check("sys_T5_redir", 64'(redirect_valid), 64'd0);
        tick();                                   // T+6
        check("sys_T6_flush", 64'(flush),        64'd0);
        check("sys_T6_ready", 64'(mm2_ready),    64'd1);
        check("sys_T6_req",   64'(csr_excp_req), 64'd0);

        // ---------------- priority ALE+ADEF ----------------
        mm2_valid    = 1'b1;
        mm2_op       = OP_NOP;
        mm2_excp_vec = NSRC'(6'b100010);
        mm2_pc       = 32'h1c00_0008;
        mm2_vaddr    = 32'h0000_0003;
        tick();
        mm2_valid    = 1'b0;
        mm2_excp_vec = '0;
        check("prio_ecode",   64'(csr_ecode),    64'h08);
        check("prio_esub",    64'(csr_esubcode), 64'd0);
        check("prio_badv",    64'(csr_badv),     64'h1c00_0008);
        check("prio_badv_we", 64'(csr_badv_we),  64'd1);
        csr_ack = 1'b1;
        tick();                                   // first FLUSH cycle
        csr_ack = 1'b0;
        mm2_valid = 1'b1;
        mm2_op    = OP_CSRXCHG;
        #1;
        check("flush_csr_we", 64'(mm2_csr_we), 64'd0);
        check("flush_flush",  64'(flush),      64'd1);
        tick();
        mm2_valid = 1'b0;
        tick();
        check("prio_idle_ready", 64'(mm2_ready),    64'd1);
        check("prio_idle_req",   64'(csr_excp_req), 64'd0);

        // ---------------- CSR write gating ----------------
        mm2_valid    = 1'b1;
        mm2_op       = OP_CSRXCHG;
        mm2_excp_vec = '0;
        #1;
        check("xchg_csr_we", 64'(mm2_csr_we), 64'd1);
        mm2_op = OP_CSRWR;
        #1;
        check("csrwr_csr_we", 64'(mm2_csr_we), 64'd1);
        mm2_op = OP_NOP;
        #1;
        check("nop_csr_we", 64'(mm2_csr_we), 64'd0);
        mm2_op       = OP_CSRXCHG;
        mm2_excp_vec = NSRC'(6'b000100);
        mm2_pc       = 32'h1c00_0300;
        #1;
        check("ine_csr_we", 64'(mm2_csr_we), 64'd0);
        tick();
        mm2_valid    = 1'b0;
        mm2_excp_vec = '0;
        check("ine_req",   64'(csr_excp_req), 64'd1);
        check("ine_ecode", 64'(csr_ecode),    64'h0D);
        check("ine_era",   64'(csr_era),      64'h1c00_0300);
        finish_req("ine");

        // ---------------- all flags: INT wins ----------------
        mm2_valid    = 1'b1;
        mm2_op       = OP_NOP;
        mm2_excp_vec = '1;
        tick();
        mm2_valid    = 1'b0;
        mm2_excp_vec = '0;
        check("int_ecode",   64'(csr_ecode),   64'h00);
        check("int_badv_we", 64'(csr_badv_we), 64'd0);
        finish_req("int");

        // ---------------- ERTN with same-cycle ack ----------------
        mm2_valid    = 1'b1;
        mm2_op       = OP_ERTN;
        mm2_excp_vec = '0;
        tick();                                   // first REQ cycle
        mm2_valid = 1'b0;
        check("ertn_req",    64'(csr_ertn_req), 64'd1);
        check("ertn_excp",   64'(csr_excp_req), 64'd0);
        csr_ack = 1'b1;
        tick();
        csr_ack = 1'b0;
        check("ertn_req_off",  64'(csr_ertn_req),   64'd0);
        check("ertn_excp_off", 64'(csr_excp_req),   64'd0);
        check("ertn_flush1",   64'(flush),          64'd1);
        check("ertn_redir",    64'(redirect_valid), 64'd1);
        tick();
        check("ertn_flush2", 64'(flush), 64'd1);
        tick();
        check("ertn_flush3",  64'(flush),     64'd0);
        check("ertn_ready",   64'(mm2_ready), 64'd1);

        // ---------------- ERTN + SYS: exception wins ----------------
        mm2_valid    = 1'b1;
        mm2_op       = OP_ERTN;
        mm2_excp_vec = NSRC'(6'b001000);
        tick();
        mm2_valid    = 1'b0;
        mm2_excp_vec = '0;
        check("ertnsys_excp", 64'(csr_excp_req), 64'd1);
        check("ertnsys_ertn", 64'(csr_ertn_req), 64'd0);
        finish_req("ertnsys");

        // ---------------- reset during REQ ----------------
        mm2_valid    = 1'b1;
        mm2_op       = OP_NOP;
        mm2_excp_vec = NSRC'(6'b010000);
        mm2_pc       = 32'h1c00_0400;
        tick();
        mm2_valid    = 1'b0;
        mm2_excp_vec = '0;
        check("brk_req",   64'(csr_excp_req), 64'd1);
        check("brk_ecode", 64'(csr_ecode),    64'h0C);
        #2;
        reset = 1'b1;
        #1;
        check("mrst_req",   64'(csr_excp_req),   64'd0);
        check("mrst_ready", 64'(mm2_ready),      64'd1);
        check("mrst_flush", 64'(flush),          64'd0);
        check("mrst_redir", 64'(redirect_valid), 64'd0);
        check("mrst_ecode", 64'(csr_ecode),      64'd0);
        tick();
        reset   = 1'b0;
        csr_ack = 1'b1;
        tick();
        csr_ack = 1'b0;
        check("stray_ack_flush", 64'(flush),        64'd0);
        check("stray_ack_ready", 64'(mm2_ready),    64'd1);
        check("stray_ack_req",   64'(csr_excp_req), 64'd0);
        tick();
        check("stray_ack_flush2", 64'(flush), 64'd0);

`ifdef TLB_EXCP_EN
        // ---------------- ADEM ----------------
        mm2_valid    = 1'b1;
        mm2_op       = OP_CSRWR;
        mm2_excp_vec = '0;
        mm2_excp_vec[6] = 1'b1;
        mm2_pc       = 32'h1c00_0500;
        mm2_vaddr    = 32'h8000_0001;
        tick();
        mm2_valid    = 1'b0;
        mm2_excp_vec = '0;
        check("adem_ecode",   64'(csr_ecode),    64'h08);
        check("adem_esub",    64'(csr_esubcode), 64'd1);
        check("adem_badv",    64'(csr_badv),     64'h8000_0001);
        check("adem_badv_we", 64'(csr_badv_we),  64'd1);
        finish_req("adem");

        // ---------------- TLBR on a fetch-class op ----------------
        mm2_valid    = 1'b1;
        mm2_op       = OP_NOP;
        mm2_excp_vec = '0;
        mm2_excp_vec[7] = 1'b1;
        mm2_pc       = 32'h1c00_0600;
        mm2_vaddr    = 32'h0000_1234;
        tick();
        mm2_valid    = 1'b0;
        mm2_excp_vec = '0;
        check("tlbr_ecode", 64'(csr_ecode), 64'h3F);
        check("tlbr_badv",  64'(csr_badv),  64'h1c00_0600);
        finish_req("tlbr");
`endif

        $display("CHECKS %0d ERRORS %0d", r_checks, r_errors);
        $finish;
    end

endmodule
`default_nettype wire
